// File: rtl/kd_tree_multi_traverser.sv
`default_nettype none
// ============================================================================
// Module      : kd_tree_multi_traverser
// Description : Level-order loaded KD tree walked by NUM_CH independent,
//               fully pipelined query channels (one tree level per stage).
// Revision    : 1.0 - initial release
// ============================================================================
module kd_tree_multi_traverser #(
    parameter int DIM_WIDTH  = 11,
    parameter int NUM_DIMS   = 5,
    parameter int TREE_DEPTH = 6,
    parameter int NUM_CH     = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      node_wr_en,
    input  logic [2*DIM_WIDTH-1:0]                    node_wr_data,
    input  logic                                      load_restart,
    output logic                                      tree_ready,
    input  logic [NUM_CH-1:0]                         patch_valid,
    input  logic [NUM_CH*DIM_WIDTH*NUM_DIMS-1:0]      patch_in,
    output logic [NUM_CH-1:0]                         leaf_valid,
    output logic [NUM_CH*TREE_DEPTH-1:0]              leaf_index,
    output logic                                      busy,
    output logic                                      err_flag,
    input  logic                                      err_clear
);
    localparam int PATCH_WIDTH = DIM_WIDTH * NUM_DIMS;
    localparam int NODE_W      = 2 * DIM_WIDTH;
    localparam int NUM_NODES   = (1 << TREE_DEPTH) - 1;
    localparam int D           = TREE_DEPTH;
    localparam int IDW         = TREE_DEPTH + 1;

    logic [NODE_W-1:0] nodes_q [NUM_NODES];
    logic [D-1:0]      wr_ptr_q, wr_ptr_d;
    logic              tree_ready_q, tree_ready_d;
    logic              err_q, err_d;
    logic              wr_accept, wr_err;
    logic [NUM_CH-1:0] ch_busy, ch_err;

    assign busy       = |ch_busy;
    assign tree_ready = tree_ready_q;
    assign err_flag   = err_q;

    // Writes are refused while any query is in flight, so no query ever sees a mixed tree.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        tree_ready_d = tree_ready_q;
        wr_accept    = 1'b0;
        wr_err       = 1'b0;
        if (load_restart) begin
            wr_ptr_d     = '0;
            tree_ready_d = 1'b0;
        end else if (node_wr_en) begin
            if (tree_ready_q || busy) begin
                wr_err = 1'b1;
            end else begin
                wr_accept = 1'b1;
                wr_ptr_d  = wr_ptr_q + D'(1);
                if (wr_ptr_q == D'(NUM_NODES - 1)) begin
                    tree_ready_d = 1'b1;
                end
            end
        end
        err_d = (err_q & ~err_clear) | wr_err | (|ch_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            tree_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            tree_ready_q <= tree_ready_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            nodes_q[wr_ptr_q] <= node_wr_data;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [D-1:0]           v_q;
        logic [PATCH_WIDTH-1:0] patch_q [D];
        logic [D-1:0]           id_q    [D];
        logic [NODE_W-1:0]      word_q  [D];
        logic [IDW-1:0]         nid     [D];
        logic [D-1:0]           dim_bad;
        logic                   fin_v_q;
        logic [D-1:0]           fin_leaf_q;
        logic                   leaf_v_q;
        logic [D-1:0]           leaf_idx_q;
        logic                   accept;

        assign accept = patch_valid[c] & tree_ready_q;

        always_comb begin
            logic [DIM_WIDTH-1:0]        dim;
            logic signed [DIM_WIDTH-1:0] med;
            logic signed [DIM_WIDTH-1:0] comp;
            dim  = '0;
            med  = '0;
            comp = '0;
            for (int k = 0; k < D; k++) begin
                dim  = word_q[k][DIM_WIDTH-1:0];
                med  = word_q[k][NODE_W-1:DIM_WIDTH];
                comp = patch_q[k][DIM_WIDTH-1:0];
                for (int d = 1; d < NUM_DIMS; d++) begin
                    if (dim == DIM_WIDTH'(d)) begin
                        comp = patch_q[k][d*DIM_WIDTH +: DIM_WIDTH];
                    end
                end
                dim_bad[k] = v_q[k] && (dim >= DIM_WIDTH'(NUM_DIMS));
                nid[k]     = (comp < med) ? {id_q[k], 1'b1}
                                          : ({id_q[k], 1'b0} + IDW'(2));
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q        <= '0;
                fin_v_q    <= 1'b0;
                leaf_v_q   <= 1'b0;
                leaf_idx_q <= '0;
            end else begin
                v_q[0] <= accept;
                for (int k = 1; k < D; k++) begin
                    v_q[k] <= v_q[k-1];
                end
                fin_v_q  <= v_q[D-1];
                leaf_v_q <= fin_v_q;
                if (fin_v_q) begin
                    leaf_idx_q <= fin_leaf_q;
                end
            end
        end

        // Each stage latches the node word it will compare against on entry.
        always_ff @(posedge clk) begin
            patch_q[0] <= patch_in[c*PATCH_WIDTH +: PATCH_WIDTH];
            id_q[0]    <= '0;
            word_q[0]  <= nodes_q[0];
            for (int k = 1; k < D; k++) begin
                patch_q[k] <= patch_q[k-1];
                id_q[k]    <= nid[k-1][D-1:0];
                word_q[k]  <= nodes_q[nid[k-1][D-1:0]];
            end
            // Final id lies in [2^D-1, 2^(D+1)-2]; subtracting 2^D-1 mod 2^D is +1 on the low bits.
            fin_leaf_q <= nid[D-1][D-1:0] + D'(1);
        end

        assign ch_busy[c]             = (|v_q) | fin_v_q;
        assign ch_err[c]              = (patch_valid[c] & ~tree_ready_q) | (|dim_bad);
        assign leaf_valid[c]          = leaf_v_q;
        assign leaf_index[c*D +: D]   = leaf_idx_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_kd_tree_multi_traverser.sv
`default_nettype none
// ============================================================================
// Module      : tb_kd_tree_multi_traverser
// Description : Scoreboard bench for kd_tree_multi_traverser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kd_tree_multi_traverser;
    localparam int DW    = 11;
    localparam int ND    = 5;
    localparam int D     = 6;
    localparam int NCH   = 2;
    localparam int PW    = DW * ND;
    localparam int NN    = (1 << D) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 node_wr_en = 1'b0;
    logic [2*DW-1:0]      node_wr_data = '0;
    logic                 load_restart = 1'b0;
    logic                 tree_ready;
    logic [NCH-1:0]       patch_valid = '0;
    logic [NCH*PW-1:0]    patch_in = '0;
    logic [NCH-1:0]       leaf_valid;
    logic [NCH*D-1:0]     leaf_index;
    logic                 busy;
    logic                 err_flag;
    logic                 err_clear = 1'b0;

    kd_tree_multi_traverser #(
        .DIM_WIDTH(DW), .NUM_DIMS(ND), .TREE_DEPTH(D), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .rst(rst), .node_wr_en(node_wr_en), .node_wr_data(node_wr_data),
        .load_restart(load_restart), .tree_ready(tree_ready), .patch_valid(patch_valid),
        .patch_in(patch_in), .leaf_valid(leaf_valid), .leaf_index(leaf_index),
        .busy(busy), .err_flag(err_flag), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int leaf;
        int cyc;
    } exp_t;

    exp_t exp_q [NCH][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tdim [NN];
    int   tmed [NN];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Leaf arrives D+2 negedges after the negedge at which the query was driven.
    task automatic push(input int c, input int leaf);
        exp_t e;
        e.leaf = leaf;
        e.cyc  = cyc + D + 2;
        exp_q[c].push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                if (leaf_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        check($sformatf("unexpected_leaf_ch%0d", c), 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[c].pop_front();
                        check($sformatf("leaf_ch%0d", c), int'(leaf_index[c*D +: D]), e.leaf);
                        check($sformatf("latency_ch%0d", c), cyc, e.cyc);
                    end
                end
            end
        end
    end

    function automatic logic [PW-1:0] mk(input int a, input int b, input int c, input int d, input int e);
        return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic int model(input logic [PW-1:0] p);
        int n;
        logic signed [DW-1:0] comp;
        n = 0;
        for (int l = 0; l < D; l++) begin
            comp = p[tdim[n]*DW +: DW];
            n = (int'(comp) < tmed[n]) ? 2*n + 1 : 2*n + 2;
        end
        return n - NN;
    endfunction

    task automatic send(input logic [NCH-1:0] vm, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                        input int e0, input int e1);
        @(negedge clk);
        patch_valid = vm;
        patch_in    = {p1, p0};
        if (vm[0]) push(0, e0);
        if (vm[1]) push(1, e1);
    endtask

    task automatic idle();
        @(negedge clk);
        patch_valid = '0;
    endtask

    task automatic load_tree();
        for (int i = 0; i < NN; i++) begin
            @(negedge clk);
            node_wr_en   = 1'b1;
            node_wr_data = {DW'(tmed[i]), DW'(tdim[i])};
        end
        @(negedge clk);
        node_wr_en = 1'b0;
        check("tree_ready_after_load", int'(tree_ready), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
        end
        check("drain_ch0", exp_q[0].size(), 0);
        check("drain_ch1", exp_q[1].size(), 0);
    endtask

    task automatic flat_tree_t1();
        for (int i = 0; i < NN; i++) begin
            tdim[i] = 0;
            tmed[i] = 0;
        end
        load_tree();
        send(2'b01, mk(5, 0, 0, 0, 0), '0, 63, 0);
        idle();
        send(2'b01, mk(-1, 0, 0, 0, 0), '0, 0, 0);
        idle();
        send(2'b01, mk(0, 0, 0, 0, 0), '0, 63, 0);
        idle();
        drain();
    endtask

    initial begin
        logic [PW-1:0] pa, pb;
        int lvl;
        int med_lvl [D];
        med_lvl = '{0, 7, -7, 3, -3, 1};

        repeat (3) @(negedge clk);
        check("reset_tree_ready", int'(tree_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err_flag), 0);
        check("reset_leaf_valid", int'(leaf_valid), 0);
        check("reset_leaf_index", int'(leaf_index), 0);
        rst = 1'b0;

        // Query before the tree is loaded: dropped and flagged
        @(negedge clk);
        patch_valid = 2'b01;
        patch_in    = {mk(0, 0, 0, 0, 0), mk(5, 0, 0, 0, 0)};
        @(negedge clk);
        patch_valid = '0;
        check("err_on_early_query", int'(err_flag), 1);
        check("busy_after_drop", int'(busy), 0);
        err_clear   = 1'b1;
        patch_valid = 2'b10;
        @(negedge clk);
        patch_valid = '0;
        check("err_new_beats_clear", int'(err_flag), 1);
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", int'(err_flag), 0);
        repeat (10) @(negedge clk);

        // Flat tree: single-channel results and latency
        flat_tree_t1();

        // Back-to-back on channel 0
        send(2'b01, mk(-1, 0, 0, 0, 0), '0, 0, 0);
        send(2'b01, mk(5, 0, 0, 0, 0), '0, 63, 0);
        send(2'b01, mk(-1, 0, 0, 0, 0), '0, 0, 0);
        idle();
        drain();

        // Write while tree is ready
        @(negedge clk);
        node_wr_en   = 1'b1;
        node_wr_data = {DW'(-100), DW'(0)};
        @(negedge clk);
        node_wr_en = 1'b0;
        check("err_write_when_ready", int'(err_flag), 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared_2", int'(err_flag), 0);

        // Restart while busy, then a write that must be ignored
        send(2'b01, mk(5, 0, 0, 0, 0), '0, 63, 0);
        @(negedge clk);
        patch_valid  = '0;
        load_restart = 1'b1;
        @(negedge clk);
        load_restart = 1'b0;
        node_wr_en   = 1'b1;
        node_wr_data = {DW'(-100), DW'(0)};
        @(negedge clk);
        node_wr_en = 1'b0;
        check("busy_during_write", int'(busy), 1);
        check("err_write_when_busy", int'(err_flag), 1);
        check("tree_ready_after_restart", int'(tree_ready), 0);
        drain();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;

        // Level-order tree with per-level medians and cycling dims
        for (int i = 0; i < NN; i++) begin
            lvl = 0;
            while (((1 << (lvl + 1)) - 1) <= i) lvl++;
            tdim[i] = i % ND;
            tmed[i] = med_lvl[lvl];
        end
        load_tree();
        check("err_after_reload", int'(err_flag), 0);
        send(2'b11, mk(100, 100, 100, 100, 100), mk(-100, -100, -100, -100, -100), 63, 0);
        pa = mk(5, -8, 2, -4, 0);
        pb = mk(-1, 10, -10, 3, -3);
        send(2'b11, pa, pb, model(pa), model(pb));
        pa = mk(0, 7, -7, 3, -3);
        pb = mk(-5, 6, 8, -2, 1);
        send(2'b11, pa, pb, model(pa), model(pb));
        pa = mk(9, -9, -8, 4, 2);
        pb = mk(1, 1, -1, -1, 0);
        send(2'b11, pa, pb, model(pa), model(pb));
        idle();
        drain();

        // Reset with queries in flight
        send(2'b01, mk(5, 0, 0, 0, 0), '0, 0, 0);
        send(2'b01, mk(-5, 0, 0, 0, 0), '0, 0, 0);
        send(2'b01, mk(5, 0, 0, 0, 0), '0, 0, 0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_tree_ready", int'(tree_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_leaf_index", int'(leaf_index), 0);
        repeat (12) @(negedge clk);
        load_restart = 1'b1;
        @(negedge clk);
        load_restart = 1'b0;
        flat_tree_t1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
